// File: rtl/paddle_controller_pkg.sv
// Shared breakout constants: screen/paddle geometry, BBGGRR colours,
// paddle FSM state and button-request types.
package paddle_controller_pkg;

    localparam int BRK_SCREEN_WIDTH = 640;
    localparam int BRK_PADDLE_WIDTH = 99;
    localparam int BRK_START_X      = 320;

    // Colours are packed as {BB, GG, RR}.
    localparam logic [5:0] COL_BLACK = 6'b00_00_00;
    localparam logic [5:0] COL_WHITE = 6'b11_11_11;
    localparam logic [5:0] COL_RED   = 6'b00_00_11;
    localparam logic [5:0] COL_GREEN = 6'b00_11_00;
    localparam logic [5:0] COL_BLUE  = 6'b11_00_00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LEFT  = 2'd1,
        REQ_RIGHT = 2'd2
    } req_t;

    // Both buttons together cancel out, the same as neither.
    function automatic req_t decode_req(input logic left, input logic right);
        if (left && !right) begin
            return REQ_LEFT;
        end else if (right && !left) begin
            return REQ_RIGHT;
        end else begin
            return REQ_NONE;
        end
    endfunction

endpackage

// File: rtl/paddle_controller_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer for a raw asynchronous button,
// followed by a 16-cycle debounce filter when PADDLE_DEBOUNCE_EN is defined.
module btn_conditioner (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    logic [1:0] sync_q;

    // Two-stage synchronizer into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

`ifdef PADDLE_DEBOUNCE_EN
    logic       db_level_q;
    logic [3:0] db_cnt_q;

    // Accept a new level only after it has been seen for 16 consecutive cycles;
    // any cycle back at the old level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q <= 1'b0;
            db_cnt_q   <= 4'd0;
        end else if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == 4'd15) begin
                db_level_q <= sync_q[1];
                db_cnt_q   <= 4'd0;
            end else begin
                db_cnt_q <= db_cnt_q + 4'd1;
            end
        end else begin
            db_cnt_q <= 4'd0;
        end
    end

    assign level_o = db_level_q;
`else
    assign level_o = sync_q[1];
`endif

endmodule

// File: rtl/paddle_controller.sv
// Breakout paddle controller: per-frame movement with acceleration, wall
// clamping and recentre. Define PADDLE_DEBOUNCE_EN to debounce the buttons.
module paddle_controller
    import paddle_controller_pkg::*;
#(
    parameter int PADDLE_WIDTH = BRK_PADDLE_WIDTH,
    parameter int SCREEN_WIDTH = BRK_SCREEN_WIDTH,
    parameter int START_X      = BRK_START_X,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       recentre,
    output logic [9:0] x,
    output logic       moving,
    output logic       at_wall
);

    // Drawn span is [x - XMIN, x + (PADDLE_WIDTH+1)/2), kept fully on screen.
    localparam int XMIN  = PADDLE_WIDTH / 2;
    localparam int XMAX  = SCREEN_WIDTH - (PADDLE_WIDTH + 1) / 2;
    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic        [9:0]  XMIN_V  = 10'(XMIN);
    localparam logic        [9:0]  XMAX_V  = 10'(XMAX);
    localparam logic        [9:0]  START_V = 10'(START_X);
    localparam logic signed [10:0] XMIN_S  = 11'(XMIN);
    localparam logic signed [10:0] XMAX_S  = 11'(XMAX);
    localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic        [3:0]  SPD_MAX = 4'(MAX_SPEED);

    logic left_lvl, right_lvl;
    req_t req;

    btn_conditioner u_cond_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_left),
        .level_o (left_lvl)
    );

    btn_conditioner u_cond_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_right),
        .level_o (right_lvl)
    );

    assign req = decode_req(left_lvl, right_lvl);

    state_t                 state_q, state_d;
    logic                   dir_q, dir_d;          // 0 = left, 1 = right
    logic       [3:0]       speed_q, speed_d;
    logic       [CNT_W-1:0] cnt_q, cnt_d;
    logic       [9:0]       x_q, x_d;
    logic                   moving_q, at_wall_q;
    logic                   do_move;
    logic signed [10:0]     x_sum;

    // State, motion registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            speed_q   <= 4'd0;
            cnt_q     <= '0;
            x_q       <= START_V;
            moving_q  <= 1'b0;
            at_wall_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            moving_q  <= (state_d == ST_MOVING);
            at_wall_q <= (x_d == XMIN_V) || (x_d == XMAX_V);
        end
    end

    // Next-state: recentre wins; otherwise act only on frame ticks, then
    // apply the move with clamping (a clamped move restarts acceleration).
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        do_move = 1'b0;
        x_sum   = '0;

        if (recentre) begin
            state_d = ST_IDLE;
            speed_d = 4'd0;
            cnt_d   = '0;
            x_d     = START_V;
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (req != REQ_NONE) begin
                        state_d = ST_MOVING;
                        dir_d   = (req == REQ_RIGHT);
                        speed_d = 4'd1;
                        cnt_d   = '0;
                        do_move = 1'b1;
                    end else begin
                        speed_d = 4'd0;
                    end
                end
                ST_MOVING: begin
                    if (req == REQ_NONE) begin
                        state_d = ST_IDLE;
                        speed_d = 4'd0;
                        cnt_d   = '0;
                    end else if ((req == REQ_RIGHT) == dir_q) begin
                        // Counter cycles 0..ACCEL_FRAMES-1; arriving at the
                        // last value bumps the speed.
                        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                        if ((cnt_d == CNT_LAST) && (speed_q < SPD_MAX)) begin
                            speed_d = speed_q + 4'd1;
                        end
                        do_move = 1'b1;
                    end else begin
                        dir_d   = ~dir_q;
                        speed_d = 4'd1;
                        cnt_d   = '0;
                        do_move = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (do_move) begin
                if (dir_d) begin
                    x_sum = $signed({1'b0, x_q}) + $signed({7'b0, speed_d});
                end else begin
                    x_sum = $signed({1'b0, x_q}) - $signed({7'b0, speed_d});
                end
                if (x_sum < XMIN_S) begin
                    x_d     = XMIN_V;
                    speed_d = 4'd1;
                    cnt_d   = '0;
                end else if (x_sum > XMAX_S) begin
                    x_d     = XMAX_V;
                    speed_d = 4'd1;
                    cnt_d   = '0;
                end else begin
                    x_d = x_sum[9:0];
                end
            end
        end
    end

    assign x       = x_q;
    assign moving  = moving_q;
    assign at_wall = at_wall_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Testbench for paddle_controller: directed vector table, hand-written
// corner sequences and randomized ticks against a frame-level model.
module tb_paddle_controller;

    localparam int XMIN = 49;
    localparam int XMAX = 590;
    localparam int MAXS = 8;
    localparam int AF   = 4;
`ifdef PADDLE_DEBOUNCE_EN
    localparam int SETTLE = 20;
`else
    localparam int SETTLE = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       recentre = 1'b0;
    logic [9:0] x;
    logic       moving;
    logic       at_wall;

    int checks = 0;
    int failures = 0;

    // Frame-level model: position, moving flag, direction, frames held in
    // the current run (speed = min(MAX, 1 + (k+1)/AF)).
    int m_x = 320;
    bit m_mov = 0;
    bit m_dir = 0;
    int m_k = 0;

    typedef struct {
        logic l;
        logic r;
        logic rc;
        logic tk;
        int   ex;
        logic em;
        logic ew;
    } vec_t;

    vec_t vecs[$];

    paddle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .frame_tick (frame_tick),
        .recentre   (recentre),
        .x          (x),
        .moving     (moving),
        .at_wall    (at_wall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_mov = 0; m_dir = 0; m_k = 0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic rc, input logic tk);
        int req;
        int spd;
        int nx;
        if (rc) begin
            m_x = 320; m_mov = 0; m_k = 0;
            return;
        end
        if (!tk) return;
        req = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
        spd = 0;
        if (req == 0) begin
            m_mov = 0; m_k = 0;
        end else if (!m_mov || ((req == 2) != m_dir)) begin
            m_mov = 1; m_dir = (req == 2); m_k = 0; spd = 1;
        end else begin
            m_k++;
            spd = 1 + (m_k + 1) / AF;
            if (spd > MAXS) spd = MAXS;
        end
        if (spd != 0) begin
            nx = m_dir ? m_x + spd : m_x - spd;
            if (nx < XMIN) begin nx = XMIN; m_k = 0; end
            else if (nx > XMAX) begin nx = XMAX; m_k = 0; end
            m_x = nx;
        end
    endtask

    // Set buttons, let them settle, then present one cycle of tick/recentre.
    task automatic do_tick(input logic l, input logic r, input logic rc, input logic tk);
        @(negedge clk);
        btn_left = l; btn_right = r;
        repeat (SETTLE) @(negedge clk);
        frame_tick = tk; recentre = rc;
        @(negedge clk);
        frame_tick = 1'b0; recentre = 1'b0;
        model_step(l, r, rc, tk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_x"}, int'(x), m_x);
        check({tag, "_moving"}, int'(moving), int'(m_mov));
        check({tag, "_at_wall"}, int'(at_wall), int'((m_x == XMIN) || (m_x == XMAX)));
    endtask

    task automatic add(input logic l, input logic r, input logic rc, input logic tk,
                       input int ex, input logic em, input logic ew);
        vec_t v;
        v.l = l; v.r = r; v.rc = rc; v.tk = tk; v.ex = ex; v.em = em; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_x", int'(x), 320);
        check("rst_moving", int'(moving), 0);
        check("rst_at_wall", int'(at_wall), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int xs[12] = '{321, 322, 323, 325, 327, 329, 331, 334, 337, 340, 343, 347};
        int n;
        logic l, r, rc, tk;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("reset_x", int'(x), 320);
        check("reset_moving", int'(moving), 0);
        check("reset_at_wall", int'(at_wall), 0);
        rst_n = 1'b1;
        model_reset();

        // Directed table: idle ticks, accelerating run, reversal, stop,
        // recentre alone and with a tick, hold without tick.
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 320, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 1, 0, 1, xs[i], 1, 0);
        add(1, 0, 0, 1, 346, 1, 0);
        add(1, 0, 0, 1, 345, 1, 0);
        add(0, 0, 0, 1, 345, 0, 0);
        add(0, 0, 1, 0, 320, 0, 0);
        add(0, 1, 1, 1, 320, 0, 0);
        add(0, 1, 0, 1, 321, 1, 0);
        add(0, 1, 0, 0, 321, 1, 0);
        add(0, 0, 0, 1, 321, 0, 0);
        foreach (vecs[i]) begin
            do_tick(vecs[i].l, vecs[i].r, vecs[i].rc, vecs[i].tk);
            check($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            check($sformatf("vec%0d_moving", i), int'(moving), int'(vecs[i].em));
            check($sformatf("vec%0d_at_wall", i), int'(at_wall), int'(vecs[i].ew));
        end

        // Left wall: approach to x<=60, stop, then hold left into the wall.
        n = 0;
        while (m_x > 60 && n < 100) begin do_tick(1, 0, 0, 1); n++; end
        do_tick(0, 0, 0, 1);
        check_model("near_wall");
        n = 0;
        while (x != 10'(XMIN) && n < 100) begin
            do_tick(1, 0, 0, 1);
            check_model("to_left_wall");
            check("x_not_below_min", int'(x >= 10'(XMIN)), 1);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            do_tick(1, 0, 0, 1);
            check("left_wall_x", int'(x), XMIN);
            check("left_wall_flag", int'(at_wall), 1);
            check("left_wall_moving", int'(moving), 1);
        end
        do_tick(0, 1, 0, 1);
        check("leave_left_wall_x", int'(x), XMIN + 1);

        // Accelerate right, then reverse: exactly one pixel back.
        for (int i = 0; i < 9; i++) do_tick(0, 1, 0, 1);
        n = int'(x);
        do_tick(1, 0, 0, 1);
        check("reverse_x", int'(x), n - 1);
        check_model("reverse");

        // Run right past 500, then recentre coincident with a tick.
        n = 0;
        while (m_x < 500 && n < 200) begin do_tick(0, 1, 0, 1); n++; end
        check_model("before_recentre");
        do_tick(0, 1, 1, 1);
        check("recentre_x", int'(x), 320);
        check("recentre_moving", int'(moving), 0);

        // Right wall clamp.
        n = 0;
        while (m_x != XMAX && n < 200) begin do_tick(0, 1, 0, 1); n++; end
        check_model("right_wall");
        check("right_wall_flag", int'(at_wall), 1);

        // Reset mid-move, first tick afterwards behaves as from IDLE.
        do_tick(1, 0, 0, 1);
        do_tick(1, 0, 0, 1);
        async_reset_pulse();
        do_tick(0, 1, 0, 1);
        check("post_reset_x", int'(x), 321);
        check("post_reset_moving", int'(moving), 1);

`ifdef PADDLE_DEBOUNCE_EN
        // Short glitch across a tick is filtered; a stable press moves once.
        do_tick(0, 0, 0, 1);
        @(negedge clk);
        btn_right = 1'b1;
        repeat (5) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        btn_right = 1'b0;
        repeat (20) @(negedge clk);
        model_step(0, 0, 0, 1);
        check("glitch_x", int'(x), 321);
        check("glitch_moving", int'(moving), 0);
        do_tick(0, 1, 0, 1);
        check("stable_press_x", int'(x), 322);
        do_tick(0, 0, 0, 1);
`endif

        // Randomized ticks with sticky buttons, occasional recentre/reset.
        l = 1'b0; r = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end
            rc = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) begin
                async_reset_pulse();
            end else begin
                do_tick(l, r, rc, tk);
                check_model($sformatf("rand%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_controller.md
PADDLE_CONTROLLER -- requirements
Module: paddle_controller

Interface
REQ-001 SHALL have parameter PADDLE_WIDTH, default 99, paddle width in pixels (odd).
REQ-002 SHALL have parameter SCREEN_WIDTH, default 640, visible width in pixels.
REQ-003 SHALL have parameter START_X, default 320, paddle centre after reset/recentre.
REQ-004 SHALL have parameter MAX_SPEED, default 8, maximum pixels moved per frame.
REQ-005 SHALL have parameter ACCEL_FRAMES, default 4, frames per +1 speed step.
REQ-006 SHALL have port clk, input, 1, system (pixel) clock.
REQ-007 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port btn_left, input, 1, raw asynchronous left button, active-high.
REQ-009 SHALL have port btn_right, input, 1, raw asynchronous right button, active-high.
REQ-010 SHALL have port frame_tick, input, 1, single-cycle pulse once per frame (start of vblank).
REQ-011 SHALL have port recentre, input, 1, synchronous single-cycle request to recentre the paddle.
REQ-012 SHALL have port x, output, 10, paddle centre x, fed to the paddle drawer.
REQ-013 SHALL have port moving, output, 1, high while state is MOVING.
REQ-014 SHALL have port at_wall, output, 1, high while x equals XMIN or XMAX.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any use.
REQ-016 SHALL derive request: LEFT if only left pressed, RIGHT if only right pressed, NONE if neither or both.
REQ-017 SHALL define XMIN = PADDLE_WIDTH/2 (49) and XMAX = SCREEN_WIDTH - (PADDLE_WIDTH+1)/2 (590), so the drawn span [x-49, x+50) stays on screen.
REQ-018 SHALL implement states IDLE and MOVING, plus registers dir (0=left,1=right), speed (4 bits), accel_cnt (ACCEL_FRAMES counter).
REQ-019 SHALL sample request and update state only on cycles where frame_tick=1; all registers hold otherwise.
REQ-020 On tick in IDLE with request NONE: stay IDLE, speed 0, x unchanged.
REQ-021 On tick in IDLE with LEFT/RIGHT: go MOVING, dir=request, speed=1, accel_cnt=0, x moves 1 pixel that same tick.
REQ-022 On tick in MOVING with request equal to dir: accel_cnt increments; when it reaches ACCEL_FRAMES-1 it wraps to 0 and speed increments, saturating at MAX_SPEED; x moves by the new speed.
REQ-023 On tick in MOVING with opposite request: dir flips, speed=1, accel_cnt=0, x moves 1 pixel in new direction.
REQ-024 On tick in MOVING with NONE: go IDLE, speed 0, accel_cnt 0, x unchanged.
REQ-025 SHALL compute the new x in 11-bit signed-safe arithmetic and clamp to [XMIN, XMAX]; no wrap-around ever.
REQ-026 When a move is clamped, SHALL set speed to 1 and accel_cnt to 0 but remain MOVING.
REQ-027 recentre SHALL set x=START_X, state IDLE, speed 0, accel_cnt 0; it has priority over a coincident frame_tick.
REQ-028 x, moving, at_wall SHALL be registered; x reflects a tick one clk after frame_tick.

Reset
REQ-029 On rst_n low, SHALL asynchronously set x=START_X, IDLE, dir=0, speed=0, accel_cnt=0, synchronizer and debounce flops 0, moving=0, at_wall=0.
REQ-030 Reset mid-move SHALL abandon motion; first tick after release behaves as IDLE.

Configuration
REQ-031 With PADDLE_DEBOUNCE_EN defined, each synchronized button SHALL change its debounced level only after 16 consecutive clk cycles at the new level (4-bit counter cleared on any mismatch).
REQ-032 Without PADDLE_DEBOUNCE_EN, the synchronized levels SHALL be used directly, and no debounce counter is present.

Structure
REQ-033 SCREEN_WIDTH, PADDLE_WIDTH, START_X and the BBGGRR colour constants SHALL live in the shared breakout constants package/include used by the drawers.
REQ-034 SHALL instantiate one sub-module btn_conditioner per button (synchronizer plus optional debounce).

Verification
REQ-035 Reset then 5 ticks, no buttons -> x=320, moving=0, at_wall=0.
REQ-036 Right held 12 ticks (ACCEL_FRAMES=4) -> speeds 1,1,1,2,2,2,2,3,3,3,3,4; x=320+27=347, moving=1.
REQ-037 Left held until wall from x=60 -> x clamps at 49, at_wall=1, speed 1, never below 49.
REQ-038 Right held to speed 3 then left pressed alone -> next tick x decreases by 1, dir=0.
REQ-039 recentre coincident with frame_tick while moving at x=500 -> x=320, moving=0.
REQ-040 With PADDLE_DEBOUNCE_EN: 10-cycle glitch on btn_right across a tick -> no movement; 20-cycle-stable press -> moves 1 pixel.
